// File: rtl/fp_addsub_pipe.sv
// Three-stage floating-point add/subtract (align, add, normalise/round) with valid/ready backpressure.
// Define FP_ADDSUB_RNE_EN for round-to-nearest-even; otherwise results are truncated toward zero.
module fp_addsub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  input  logic                   sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   sum,
  output logic                   ovf,
  output logic                   unf,
  output logic                   inv
);
  localparam int W      = 1 + EXP_W + MAN_W;
  localparam int N      = MAN_W + 4;
  localparam int LZ_L   = $clog2(N);
  localparam int EW     = EXP_W + 2;
  localparam int STAGES = 3;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  logic [STAGES:1] vld_q;
  logic            adv;
  assign adv       = ~vld_q[STAGES] | out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_q[STAGES];

  // S1: unpack, flush, swap, align
  logic             sa, sb, az, bz, a_nan, b_nan, a_inf, b_inf, a_big;
  logic [EXP_W-1:0] ea, eb, big_e, dexp;
  logic [MAN_W:0]   sig_a, sig_b, big_sig, sml_sig;
  logic [N-1:0]     sml_ext, sml_sh, s1_sml_d;
  logic             lost;
  logic             s1_spec_d, s1_inv_d;
  logic [W-1:0]     s1_sval_d;

  assign sa    = a[W-1];
  assign sb    = b[W-1] ^ sub;
  assign ea    = a[W-2:MAN_W];
  assign eb    = b[W-2:MAN_W];
  assign az    = ~|ea;
  assign bz    = ~|eb;
  assign a_nan = &ea & |a[MAN_W-1:0];
  assign b_nan = &eb & |b[MAN_W-1:0];
  assign a_inf = &ea & ~|a[MAN_W-1:0];
  assign b_inf = &eb & ~|b[MAN_W-1:0];
  assign sig_a = az ? '0 : {1'b1, a[MAN_W-1:0]};
  assign sig_b = bz ? '0 : {1'b1, b[MAN_W-1:0]};
  assign a_big = {ea, sig_a} >= {eb, sig_b};
  assign big_e   = a_big ? ea : eb;
  assign big_sig = a_big ? sig_a : sig_b;
  assign sml_sig = a_big ? sig_b : sig_a;
  assign dexp    = a_big ? (ea - eb) : (eb - ea);
  assign sml_ext = {sml_sig, 3'b000};
  assign sml_sh  = sml_ext >> dexp;
  assign lost    = |(sml_ext & ~({N{1'b1}} << dexp));
  assign s1_sml_d = (int'(dexp) >= MAN_W + 3) ? {{(N-1){1'b0}}, |sml_sig}
                                              : {sml_sh[N-1:1], sml_sh[0] | lost};
  assign s1_spec_d = a_nan | b_nan | a_inf | b_inf;
  assign s1_inv_d  = a_nan | b_nan | (a_inf & b_inf & (sa ^ sb));
  assign s1_sval_d = s1_inv_d ? QNAN
                   : {a_inf ? sa : sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};

  logic             s1_sign_q, s1_esub_q, s1_neg0_q, s1_spec_q, s1_inv_q;
  logic [EXP_W-1:0] s1_exp_q;
  logic [N-1:0]     s1_big_q, s1_sml_q;
  logic [W-1:0]     s1_sval_q;

  // S2: significand add/subtract; big >= small so the difference never goes negative
  logic [N:0]       s2_sum_d, s2_sum_q;
  logic             s2_sign_q, s2_neg0_q, s2_spec_q, s2_inv_q;
  logic [EXP_W-1:0] s2_exp_q;
  logic [W-1:0]     s2_sval_q;

  assign s2_sum_d = s1_esub_q ? ({1'b0, s1_big_q} - {1'b0, s1_sml_q})
                              : ({1'b0, s1_big_q} + {1'b0, s1_sml_q});

  always_ff @(posedge clk) begin
    if (adv) begin
      s1_sign_q <= a_big ? sa : sb;
      s1_exp_q  <= big_e;
      s1_big_q  <= {big_sig, 3'b000};
      s1_sml_q  <= s1_sml_d;
      s1_esub_q <= sa ^ sb;
      s1_neg0_q <= sa & sb;
      s1_spec_q <= s1_spec_d;
      s1_inv_q  <= s1_inv_d;
      s1_sval_q <= s1_sval_d;
      s2_sum_q  <= s2_sum_d;
      s2_sign_q <= s1_sign_q;
      s2_exp_q  <= s1_exp_q;
      s2_neg0_q <= s1_neg0_q;
      s2_spec_q <= s1_spec_q;
      s2_inv_q  <= s1_inv_q;
      s2_sval_q <= s1_sval_q;
    end
  end

  // S3: log-shifter normalise; each level shifts when its top slice is all zero
  logic [N-1:0]    nv [0:LZ_L];
  logic [LZ_L-1:0] nc [0:LZ_L];
  assign nv[0] = s2_sum_q[N-1:0];
  assign nc[0] = '0;
  for (genvar k = 0; k < LZ_L; k++) begin : g_norm
    localparam int SH = 1 << (LZ_L - 1 - k);
    logic top_zero;
    assign top_zero  = ~|nv[k][N-1 -: SH];
    assign nv[k+1]   = top_zero ? (nv[k] << SH) : nv[k];
    assign nc[k+1]   = top_zero ? nc[k] + LZ_L'(SH) : nc[k];
  end

  logic          carry;
  logic [N-1:0]  m;
  logic [EW-1:0] e1, e_f;
  logic [MAN_W:0] sig_f;
  assign carry = s2_sum_q[N];
  assign m  = carry ? {s2_sum_q[N:2], s2_sum_q[1] | s2_sum_q[0]} : nv[LZ_L];
  assign e1 = carry ? ({2'b00, s2_exp_q} + EW'(1)) : ({2'b00, s2_exp_q} - EW'(nc[LZ_L]));

`ifdef FP_ADDSUB_RNE_EN
  logic           inc;
  logic [MAN_W+1:0] mr;
  assign inc   = m[2] & (m[1] | m[0] | m[3]);
  assign mr    = {1'b0, m[N-1:3]} + {{(MAN_W+1){1'b0}}, inc};
  assign sig_f = mr[MAN_W+1] ? mr[MAN_W+1:1] : mr[MAN_W:0];
  assign e_f   = mr[MAN_W+1] ? e1 + EW'(1) : e1;
`else
  logic grs_unused;
  assign grs_unused = |m[2:0];
  assign sig_f = m[N-1:3];
  assign e_f   = e1;
`endif

  logic [W-1:0] sum_d;
  logic         ovf_d, unf_d, inv_d;
  always_comb begin
    sum_d = {s2_sign_q, e_f[EXP_W-1:0], sig_f[MAN_W-1:0]};
    ovf_d = 1'b0;
    unf_d = 1'b0;
    inv_d = 1'b0;
    if (s2_spec_q) begin
      sum_d = s2_sval_q;
      inv_d = s2_inv_q;
    end else if (s2_sum_q == '0) begin
      sum_d = {s2_neg0_q, {(W-1){1'b0}}};
    end else if (e_f[EW-1] || e_f == '0) begin
      sum_d = {s2_sign_q, {(W-1){1'b0}}};
      unf_d = 1'b1;
    end else if (e_f >= EW'((1 << EXP_W) - 1)) begin
      ovf_d = 1'b1;
`ifdef FP_ADDSUB_RNE_EN
      sum_d = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
`else
      sum_d = {s2_sign_q, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      sum   <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
      inv   <= 1'b0;
    end else if (adv) begin
      vld_q <= {vld_q[STAGES-1:1], in_valid};
      if (vld_q[STAGES-1]) begin
        sum <= sum_d;
        ovf <= ovf_d;
        unf <= unf_d;
        inv <= inv_d;
      end
    end
  end
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed bench for fp_addsub_pipe: single-precision vectors, stall stream, reset flush, double-precision smoke.
module tb_fp_addsub_pipe;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_ready, sub = 1'b0;
  logic [31:0] a = '0, b = '0, sum;
  logic        out_valid, out_ready = 1'b1, ovf, unf, inv;

  logic        d_in_valid = 1'b0, d_in_ready, d_out_valid, d_ovf, d_unf, d_inv;
  logic [63:0] d_a = '0, d_b = '0, d_sum;

  int checks = 0;
  int errors = 0;

`ifdef FP_ADDSUB_RNE_EN
  localparam logic [31:0] EXP_RND = 32'h3F800002;
  localparam logic [31:0] EXP_OVF = 32'h7F800000;
`else
  localparam logic [31:0] EXP_RND = 32'h3F800001;
  localparam logic [31:0] EXP_OVF = 32'h7F7FFFFF;
`endif

  always #5 clk = ~clk;

  fp_addsub_pipe u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .ovf(ovf), .unf(unf), .inv(inv)
  );

  fp_addsub_pipe #(.EXP_W(11), .MAN_W(52)) u_dp (
    .clk(clk), .rst(rst), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .a(d_a), .b(d_b), .sub(1'b0), .out_valid(d_out_valid), .out_ready(1'b1),
    .sum(d_sum), .ovf(d_ovf), .unf(d_unf), .inv(d_inv)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents one op, then counts edges until out_valid (bounded).
  task automatic run_op(input logic [31:0] ia, input logic [31:0] ib, input logic isub, output int lat);
    @(negedge clk);
    a = ia; b = ib; sub = isub; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic vec(input string tag, input logic [31:0] ia, input logic [31:0] ib, input logic isub,
                     input logic [31:0] exp_sum, input logic [2:0] exp_flags);
    int lat;
    run_op(ia, ib, isub, lat);
    check({tag, "_lat"}, 64'(lat), 64'd3);
    check({tag, "_sum"}, 64'(sum), 64'(exp_sum));
    check({tag, "_flags"}, 64'({ovf, unf, inv}), 64'(exp_flags));
  endtask

  logic [31:0] sa_op [4] = '{32'h3F800000, 32'h40000000, 32'h3FC00000, 32'h40400000};
  logic [31:0] sb_op [4] = '{32'h40000000, 32'h3F800000, 32'h3E800000, 32'h40A00000};
  logic        ss_op [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic [31:0] se_op [4] = '{32'h40400000, 32'h3F800000, 32'h3FE00000, 32'hC0000000};

  initial begin
    int idx, ng, lat, dl;
    logic [31:0] held;
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_flags", 64'({ovf, unf, inv}), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    vec("one_plus_two",  32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000);
    vec("one_minus_one", 32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000);
    vec("negz_plus_negz",32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000);
    vec("negz_minus_z",  32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 3'b000);
    vec("round",         32'h3F800001, 32'h33800000, 1'b0, EXP_RND,      3'b000);
    vec("overflow",      32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, EXP_OVF,      3'b100);
    vec("inf_minus_inf", 32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b001);
    vec("inf_plus_one",  32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 3'b000);
    vec("nan_plus_one",  32'h7FC00123, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b001);
    vec("underflow",     32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 3'b010);
    vec("denorm_flush",  32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 3'b000);

    // Stream of 4 with consumer stalled on cycles 3 and 4
    idx = 0; ng = 0; held = '0;
    for (int c = 0; c < 30 && ng < 4; c++) begin
      @(negedge clk);
      out_ready = !(c == 3 || c == 4);
      in_valid  = (idx < 4);
      if (idx < 4) begin a = sa_op[idx]; b = sb_op[idx]; sub = ss_op[idx]; end
      #1;
      if (c == 3) begin
        check("stall_in_ready", 64'(in_ready), 64'd0);
        check("stall_out_valid", 64'(out_valid), 64'd1);
        held = sum;
      end
      if (c == 4) begin
        check("stall_in_ready2", 64'(in_ready), 64'd0);
        check("stall_hold", 64'(sum), 64'(held));
      end
      if (out_valid && out_ready) begin
        check($sformatf("stream_res%0d", ng), 64'(sum), 64'(se_op[ng]));
        ng++;
      end
      if (in_valid && in_ready) idx++;
    end
    check("stream_count", 64'(ng), 64'd4);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("stream_drain", 64'(out_valid), 64'd0);

    // Reset with 3 ops in flight
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a = sa_op[i]; b = sb_op[i]; sub = ss_op[i]; in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    run_op(32'h40000000, 32'h40000000, 1'b0, lat);
    check("post_rst_lat", 64'(lat), 64'd3);
    check("post_rst_sum", 64'(sum), 64'h40800000);

    // Double precision 1.0 + 1.0
    @(negedge clk);
    d_a = 64'h3FF0000000000000; d_b = 64'h3FF0000000000000; d_in_valid = 1'b1;
    @(negedge clk);
    d_in_valid = 1'b0;
    dl = 1;
    while (!d_out_valid && dl < 10) begin
      @(negedge clk);
      dl++;
    end
    check("dp_lat", 64'(dl), 64'd3);
    check("dp_sum", d_sum, 64'h4000000000000000);
    check("dp_flags", 64'({d_ovf, d_unf, d_inv}), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
